// File: rtl/trellis_pkg.sv
// Shared types and constants for the trellis termination tail generator.
package trellis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN1 = 2'd1,
        GEN2 = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam int         DEF_MEM     = 3;
    localparam logic [2:0] DEF_FB_POLY = 3'b110;
    localparam logic [2:0] DEF_FF_POLY = 3'b101;

    function automatic int TAIL_LEN(input int mem);
        return 4 * mem;
    endfunction

endpackage

// File: rtl/rsc_term_step.sv
// One trellis-termination step of a recursive systematic encoder: the input bit
// equals the feedback, so the register is flushed towards zero.
module rsc_term_step #(
    parameter int             MEM     = 3,
    parameter logic [MEM-1:0] FB_POLY = 3'b110,
    parameter logic [MEM-1:0] FF_POLY = 3'b101
) (
    input  logic [MEM-1:0] i_s,
    output logic           o_x,
    output logic           o_z,
    output logic [MEM-1:0] o_s_next
);

    // bit j-1 holds s[j]; x = fb, z = parity taps of the current state
    assign o_x      = ^(i_s & FB_POLY);
    assign o_z      = ^(i_s & FF_POLY);
    assign o_s_next = {i_s[MEM-2:0], 1'b0};

endmodule

// File: rtl/trellis_term_gen.sv
// Generates the 4*MEM turbo tail bits from two final encoder states and streams
// them out serially. Define TRELLIS_3GPP_ORDER_EN for the d0/d1/d2 interleaved order.
module trellis_term_gen
    import trellis_pkg::*;
#(
    parameter int             MEM     = DEF_MEM,
    parameter logic [MEM-1:0] FB_POLY = DEF_FB_POLY,
    parameter logic [MEM-1:0] FF_POLY = DEF_FF_POLY
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [MEM-1:0] state1,
    input  logic [MEM-1:0] state2,
    input  logic           out_ready,
    output logic           tail_valid,
    output logic           tail_bit,
    output logic           busy,
    output logic           done
);

    localparam int L  = TAIL_LEN(MEM);
    localparam int IW = $clog2(L);
    localparam int SW = $clog2(MEM);

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0][MEM-1:0]  r_s;
    logic [1:0][MEM-1:0]  w_s_next;
    logic [1:0]           w_x;
    logic [1:0]           w_z;
    logic [SW-1:0]        r_step;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_rd_k;
    logic [IW-1:0]        w_wr_k;
    logic [L-1:0]         r_tail;
    logic                 r_done;
    logic                 w_enc;
    logic                 w_last_step;
    logic                 w_last_bit;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_enc
            rsc_term_step #(
                .MEM     (MEM),
                .FB_POLY (FB_POLY),
                .FF_POLY (FF_POLY)
            ) u_step (
                .i_s      (r_s[gi]),
                .o_x      (w_x[gi]),
                .o_z      (w_z[gi]),
                .o_s_next (w_s_next[gi])
            );
        end
    endgenerate

    assign w_enc       = (r_state == GEN2);
    assign w_last_step = (r_step == SW'(MEM - 1));
    assign w_last_bit  = (r_idx == IW'(L - 1));
    assign w_wr_k      = (w_enc ? IW'(2 * MEM) : IW'(0)) + IW'({r_step, 1'b0});

`ifdef TRELLIS_3GPP_ORDER_EN
    // Emission index -> buffer index: all k%3==0 first, then k%3==1, then k%3==2.
    localparam int N0 = (L + 2) / 3;
    localparam int N1 = (L + 1) / 3;
    always_comb begin
        w_rd_k = '0;
        if (r_idx < IW'(N0))
            w_rd_k = IW'(3) * r_idx;
        else if (r_idx < IW'(N0 + N1))
            w_rd_k = IW'(3) * (r_idx - IW'(N0)) + IW'(1);
        else
            w_rd_k = IW'(3) * (r_idx - IW'(N0 + N1)) + IW'(2);
    end
`else
    assign w_rd_k = r_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        tail_valid   = 1'b0;
        tail_bit     = 1'b0;
        case (r_state)
            IDLE: if (load) w_state_next = GEN1;
            GEN1: begin
                busy = 1'b1;
                if (w_last_step) w_state_next = GEN2;
            end
            GEN2: begin
                busy = 1'b1;
                if (w_last_step) w_state_next = SEND;
            end
            SEND: begin
                busy       = 1'b1;
                tail_valid = 1'b1;
                tail_bit   = r_tail[w_rd_k];
                if (out_ready && w_last_bit) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_step <= '0;
            r_idx  <= '0;
            r_tail <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_s[0] <= state1;
                        r_s[1] <= state2;
                        r_step <= '0;
                        r_idx  <= '0;
                    end
                end
                GEN1, GEN2: begin
                    r_s[w_enc]               <= w_s_next[w_enc];
                    r_tail[w_wr_k]           <= w_x[w_enc];
                    r_tail[w_wr_k + IW'(1)]  <= w_z[w_enc];
                    r_step                   <= w_last_step ? '0 : r_step + SW'(1);
                end
                SEND: begin
                    if (out_ready) begin
                        r_done <= w_last_bit;
                        r_idx  <= w_last_bit ? '0 : r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trellis_term_gen.sv
// Self-checking bench for trellis_term_gen: random encoder states, random
// back-pressure and mid-frame resets against a bit-level reference model.
module tb_trellis_term_gen;
    import trellis_pkg::*;

    localparam int         MEM = 3;
    localparam int         L   = 4 * MEM;
    localparam logic [2:0] FB  = 3'b110;
    localparam logic [2:0] FF  = 3'b101;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load = 1'b0;
    logic [MEM-1:0] state1 = '0;
    logic [MEM-1:0] state2 = '0;
    logic           out_ready = 1'b0;
    logic           tail_valid;
    logic           tail_bit;
    logic           busy;
    logic           done;

    int total = 0;
    int bad   = 0;

    trellis_term_gen #(.MEM(MEM), .FB_POLY(FB), .FF_POLY(FF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .state1     (state1),
        .state2     (state2),
        .out_ready  (out_ready),
        .tail_valid (tail_valid),
        .tail_bit   (tail_bit),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: flush each encoder by feeding back its own feedback bit, then order the buffer.
    function automatic logic [L-1:0] ref_tail(input logic [MEM-1:0] a, input logic [MEM-1:0] b);
        int             s [1:MEM];
        int             t [0:L-1];
        logic [MEM-1:0] fbp;
        logic [MEM-1:0] ffp;
        logic [MEM-1:0] init;
        logic [L-1:0]   seq;
        int             k;
        int             n;
        int             fbv;
        int             zv;
        fbp = FB;
        ffp = FF;
        seq = '0;
        k   = 0;
        for (int e = 0; e < 2; e++) begin
            init = (e == 0) ? a : b;
            for (int j = 1; j <= MEM; j++) s[j] = int'(init[j-1]);
            for (int st = 0; st < MEM; st++) begin
                fbv = 0;
                zv  = 0;
                for (int j = 1; j <= MEM; j++) begin
                    if (fbp[j-1]) fbv = fbv ^ s[j];
                    if (ffp[j-1]) zv  = zv ^ s[j];
                end
                t[k]   = fbv;
                t[k+1] = zv;
                k      = k + 2;
                for (int j = MEM; j >= 2; j--) s[j] = s[j-1];
                s[1] = 0;
            end
        end
        n = 0;
`ifdef TRELLIS_3GPP_ORDER_EN
        for (int r = 0; r < 3; r++)
            for (int kk = r; kk < L; kk += 3) begin
                seq[n] = t[kk][0];
                n++;
            end
`else
        for (int kk = 0; kk < L; kk++) begin
            seq[n] = t[kk][0];
            n++;
        end
`endif
        return seq;
    endfunction

    // Runs one frame; reports collected bits, latency, valid-to-done span and handshake anomalies.
    task automatic collect(input logic [MEM-1:0] a, input logic [MEM-1:0] b,
                           input int stall_pct, input bit inject,
                           output logic [L-1:0] got, output int lat, output int span,
                           output int ndone, output int nstall_bad, output bit done_end,
                           output bit timeout);
        int   n;
        bit   prev_stall;
        logic prev_bit;
        bit   rdy;
        got = '0; ndone = 0; nstall_bad = 0; timeout = 1'b0; done_end = 1'b0; span = 0;
        state1 = a; state2 = b; out_ready = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        lat  = 1;
        while (!tail_valid && lat < 200) begin
            if (done) ndone++;
            load = (inject && lat == 2);
            if (load) begin
                state1 = MEM'($urandom);
                state2 = MEM'($urandom);
            end
            tick();
            lat++;
        end
        load = 1'b0;
        if (!tail_valid) timeout = 1'b1;
        n = 0; prev_stall = 1'b0; prev_bit = 1'b0;
        while (n < L && span < 2000 && !timeout) begin
            if (done) ndone++;
            if (prev_stall && tail_bit !== prev_bit) nstall_bad++;
            load = (inject && span == 3);
            rdy  = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            out_ready = rdy;
            if (tail_valid && rdy) begin
                got[n] = tail_bit;
                n++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = tail_valid;
                prev_bit   = tail_bit;
            end
            tick();
            span++;
        end
        load = 1'b0;
        out_ready = 1'b0;
        if (n < L) timeout = 1'b1;
        done_end = done;
        if (done) ndone++;
        tick();
        if (done) ndone++;
        $display("frame: s1=%b s2=%b stall=%0d inject=%0d bits=%b lat=%0d span=%0d dones=%0d",
                 a, b, stall_pct, inject, got, lat, span, ndone);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        state1 = 3'b111;
        repeat (3) tick();
        total++; if (tail_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", tail_valid); end
        total++; if (tail_bit !== 1'b0)   begin bad++; $display("FAIL reset_bit: got %b want 0", tail_bit); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero();
        logic [L-1:0] got;
        int lat, span, nd, nsb;
        bit de, to;
        collect('0, '0, 0, 1'b0, got, lat, span, nd, nsb, de, to);
        total++; if (to) begin bad++; $display("FAIL zero_timeout: got timeout want frame"); end
        total++; if (got !== '0) begin bad++; $display("FAIL zero_bits: got %b want %b", got, {L{1'b0}}); end
        total++; if (lat !== 2*MEM+1) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, 2*MEM+1); end
        // first valid counted as cycle 1, done lands on cycle L+1
        total++; if (span !== L) begin bad++; $display("FAIL zero_done_span: got %0d want %0d", span, L); end
        total++; if (de !== 1'b1) begin bad++; $display("FAIL zero_done_pulse: got %b want 1", de); end
        total++; if (nd !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_known_vector();
        int exp_bits [L];
        logic [L-1:0] got;
        int lat, span, nd, nsb;
        bit de, to;
`ifdef TRELLIS_3GPP_ORDER_EN
        exp_bits = '{0,0,0,0,1,1,0,0,1,1,0,0};
`else
        exp_bits = '{0,1,1,0,1,1,0,0,0,0,0,0};
`endif
        collect(3'b001, 3'b000, 0, 1'b0, got, lat, span, nd, nsb, de, to);
        total++; if (to) begin bad++; $display("FAIL known_timeout: got timeout want frame"); end
        for (int i = 0; i < L; i++) begin
            total++;
            if (got[i] !== exp_bits[i][0]) begin
                bad++;
                $display("FAIL known_bit%0d: got %b want %0d", i, got[i], exp_bits[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [L-1:0] got, want;
        logic [MEM-1:0] a, b;
        int lat, span, nd, nsb;
        bit de, to;
        for (int it = 0; it < 6; it++) begin
            a = MEM'($urandom); b = MEM'($urandom);
            want = ref_tail(a, b);
            collect(a, b, 0, 1'b0, got, lat, span, nd, nsb, de, to);
            total++;
            if (to || got !== want) begin bad++; $display("FAIL random_bits: got %b want %b (timeout=%0d)", got, want, to); end
            total++; if (lat !== 2*MEM+1) begin bad++; $display("FAIL random_latency: got %0d want %0d", lat, 2*MEM+1); end
        end
    endtask

    task automatic test_stall();
        logic [L-1:0] got, want;
        logic [MEM-1:0] a, b;
        int lat, span, nd, nsb;
        bit de, to;
        for (int it = 0; it < 4; it++) begin
            a = MEM'($urandom); b = MEM'($urandom);
            want = ref_tail(a, b);
            collect(a, b, 45, 1'b0, got, lat, span, nd, nsb, de, to);
            total++;
            if (to || got !== want) begin bad++; $display("FAIL stall_bits: got %b want %b (timeout=%0d)", got, want, to); end
            total++; if (nsb !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", nsb); end
            total++; if (nd !== 1) begin bad++; $display("FAIL stall_done_count: got %0d want 1", nd); end
        end
    endtask

    task automatic test_load_ignored();
        logic [L-1:0] got, want;
        logic [MEM-1:0] a, b;
        int lat, span, nd, nsb;
        bit de, to;
        for (int it = 0; it < 3; it++) begin
            a = MEM'($urandom); b = MEM'($urandom);
            want = ref_tail(a, b);
            collect(a, b, 0, 1'b1, got, lat, span, nd, nsb, de, to);
            total++;
            if (to || got !== want) begin bad++; $display("FAIL ignore_bits: got %b want %b (timeout=%0d)", got, want, to); end
            total++; if (nd !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
            total++; if (span !== L) begin bad++; $display("FAIL ignore_span: got %0d want %0d", span, L); end
        end
    endtask

    task automatic test_reset_mid_send();
        logic [L-1:0] got, want;
        logic [MEM-1:0] b;
        int lat, span, nd, nsb, w;
        bit de, to;
        b = MEM'($urandom);
        want = ref_tail(3'b001, b);
        state1 = 3'b001; state2 = b; load = 1'b1;
        tick();
        load = 1'b0;
        w = 0;
        while (!tail_valid && w < 200) begin tick(); w++; end
        total++; if (!tail_valid) begin bad++; $display("FAIL rstmid_valid: got %b want 1", tail_valid); end
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        total++; if (tail_bit !== want[4]) begin bad++; $display("FAIL rstmid_bit4: got %b want %b", tail_bit, want[4]); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (tail_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async_valid: got %b want 0", tail_valid); end
        total++; if (tail_bit !== 1'b0)   begin bad++; $display("FAIL rstmid_async_bit: got %b want 0", tail_bit); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rstmid_async_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL rstmid_async_done: got %b want 0", done); end
        repeat (3) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got %b want 0", done); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_release_done: got %b want 0", done); end
        $display("reset: asserted at SEND bit 4, released");
        collect(3'b001, b, 0, 1'b0, got, lat, span, nd, nsb, de, to);
        total++;
        if (to || got !== want) begin bad++; $display("FAIL rstmid_fresh_bits: got %b want %b (timeout=%0d)", got, want, to); end
        total++; if (nd !== 1) begin bad++; $display("FAIL rstmid_fresh_done: got %0d want 1", nd); end
    endtask

    task automatic test_back_to_back();
        logic [L-1:0] got, want;
        logic [MEM-1:0] a, b;
        int lat, span, nd, nsb;
        bit de, to;
        // collect leaves the bench in the cycle right after done, so each load lands there
        for (int it = 0; it < 3; it++) begin
            a = MEM'($urandom); b = MEM'($urandom);
            want = ref_tail(a, b);
            collect(a, b, 0, 1'b0, got, lat, span, nd, nsb, de, to);
            total++;
            if (to || got !== want) begin bad++; $display("FAIL b2b_bits: got %b want %b (timeout=%0d)", got, want, to); end
            total++; if (lat !== 2*MEM+1) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, 2*MEM+1); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_known_vector();
        test_random();
        test_stall();
        test_load_ignored();
        test_reset_mid_send();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trellis_term_gen.md
TRELLIS_TERM_GEN -- requirements
Module: trellis_term_gen

Interface
REQ-001 SHALL have parameter MEM, default 3: constituent-encoder memory length (legal 2..8).
REQ-002 SHALL have parameter FB_POLY, default 3'b110: feedback taps, bit j-1 set means s[j] is tapped (MEM bits wide).
REQ-003 SHALL have parameter FF_POLY, default 3'b101: parity taps, same encoding as FB_POLY.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port load, input, 1 bit: one-cycle start request.
REQ-007 SHALL have ports state1 and state2, input, MEM bits each: final register contents of encoders 1 and 2, where bit j-1 holds s[j] and s[1] is the newest stage.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts tail_bit.
REQ-009 SHALL have port tail_valid, output, 1 bit: tail_bit is valid.
REQ-010 SHALL have port tail_bit, output, 1 bit: serial tail bit.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the last accepted bit.

Function
REQ-013 SHALL use FSM states IDLE, GEN1, GEN2, SEND.
REQ-014 SHALL, in IDLE with load=1, capture state1 and state2 into internal registers and move to GEN1 on the next edge.
REQ-015 SHALL ignore load while busy=1.
REQ-016 SHALL, on each GEN step: fb = XOR of s[j] over FB_POLY taps; x = fb; z = XOR of s[j] over FF_POLY taps; then s[j] <= s[j-1] for j > 1 and s[1] <= 0.
REQ-017 SHALL spend MEM cycles in GEN1 (encoder 1), then MEM cycles in GEN2 (encoder 2).
REQ-018 SHALL write tail buffer t[0..4*MEM-1] in the order x1_0, z1_0, x1_1, z1_1, ..., then x2_0, z2_0, and so on.
REQ-019 SHALL enter SEND after the last GEN2 step, with tail_valid=1 and a bit index starting at 0.
REQ-020 SHALL advance the index only on a cycle with tail_valid and out_ready both high; tail_bit SHALL remain stable while out_ready=0.
REQ-021 SHALL, on acceptance of the bit at index 4*MEM-1, drop tail_valid, pulse done for 1 cycle and return to IDLE.
REQ-022 SHALL give latency from load to the first tail_valid of exactly 2*MEM+1 cycles.
REQ-023 SHALL accept a load in the cycle immediately after done.

Reset
REQ-024 SHALL, while rst_n=0, put the FSM in IDLE and force tail_valid=0, tail_bit=0, busy=0, done=0, with buffer, index and state registers all zero.
REQ-025 SHALL, on reset asserted mid-GEN or mid-SEND, abort immediately with no done pulse.

Configuration
REQ-026 SHALL, with TRELLIS_3GPP_ORDER_EN defined, emit the t[k] with k mod 3 = 0 in ascending k, then those with k mod 3 = 1, then those with k mod 3 = 2 (36.212 d0/d1/d2 tail mapping).
REQ-027 SHALL, with TRELLIS_3GPP_ORDER_EN undefined, emit t[0] through t[4*MEM-1] in natural order.

Structure
REQ-028 SHALL place the FSM state enum, the default polynomials and the TAIL_LEN(MEM)=4*MEM helper in package trellis_pkg.
REQ-029 SHALL instantiate the step logic of REQ-016 as sub-module rsc_term_step, used for both encoders; the FSM and serialiser SHALL stay in the top.

Verification
REQ-030 SHALL cover: state1=0, state2=0, load, out_ready=1 -> 12 zero bits, then done 13 cycles after the first valid.
REQ-031 SHALL cover: state1=3'b001, state2=0, natural order -> 0,1,1,0,1,1,0,0,0,0,0,0.
REQ-032 SHALL cover: the same stimulus as REQ-031 with TRELLIS_3GPP_ORDER_EN -> 0,0,0,0,1,1,0,0,1,1,0,0.
REQ-033 SHALL cover: out_ready toggled at random during SEND -> same sequence as without stalls, tail_bit stable in every stall cycle, done exactly once.
REQ-034 SHALL cover: load re-asserted during GEN1 and SEND -> ignored, with output identical to a single load.
REQ-035 SHALL cover: rst_n low at the 5th SEND bit -> all outputs 0 asynchronously, no done pulse, and a fresh load then produces the full correct sequence.
